// File: rtl/nmea_pkg.sv
// Shared ASCII constants, parser state encoding and character-class helpers
// for the NMEA RMC sentence parser.
package nmea_pkg;

   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;
   localparam logic [7:0] CH_A      = 8'h41;
   localparam logic [7:0] CH_V      = 8'h56;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      IGNORE = 3'd2,
      FIELD  = 3'd3,
      CK_HI  = 3'd4,
      CK_LO  = 3'd5
   } state_t;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

endpackage

// File: rtl/nmea_hex_nibble.sv
// ASCII hex character to 4-bit value; accepts 0-9, A-F and a-f.
module nmea_hex_nibble (
   input  logic [7:0] data,
   output logic       ok,
   output logic [3:0] nibble
);

   always_comb begin
      ok     = 1'b0;
      nibble = 4'h0;
      if ((data >= 8'h30) && (data <= 8'h39)) begin
         ok     = 1'b1;
         nibble = data[3:0];
      end else if (((data >= 8'h41) && (data <= 8'h46)) ||
                   ((data >= 8'h61) && (data <= 8'h66))) begin
         // 'A'/'a' have low nibble 1, so +9 lands on 10
         ok     = 1'b1;
         nibble = data[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/nmea_rmc_parser.sv
// Parses $xxRMC sentences from a UART byte stream, checks the XOR checksum and
// latches UTC time (BCD hhmmss) and fix status on every good sentence.
module nmea_rmc_parser
   import nmea_pkg::*;
#(
   parameter int          maxlen   = 82,
   parameter logic [23:0] sentence = "RMC"
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  data,
   input  logic        valid,
   output logic [23:0] time_bcd,
   output logic        fix,
   output logic        update,
   output logic        err,
   output logic [2:0]  fsm_state
);

   localparam logic [7:0] MAXLEN = 8'(maxlen);

   // Byte handshake: a byte is consumed in every cycle where valid=1 (there
   // is no back-pressure); data is only looked at in those cycles.

   state_t      state;
   logic [7:0]  csum;
   logic [6:0]  len;
   logic [3:0]  fld;
   logic [2:0]  dcnt;
   logic        bad;
   logic [23:0] sh_time;
   logic        sh_fix;
   logic [15:0] addr_sr;
   logic [3:0]  ck_hi;

   logic        hex_ok;
   logic [3:0]  hex_val;
   logic [6:0]  len_inc;
   logic        over_len;
   logic        is_eol;
   logic        in_match;

   nmea_hex_nibble u_hex (
      .data   (data),
      .ok     (hex_ok),
      .nibble (hex_val)
   );

   assign len_inc   = len + 7'd1;
   assign over_len  = {1'b0, len_inc} > MAXLEN;
   assign is_eol    = (data == CH_CR) || (data == CH_LF);
   assign in_match  = (state == FIELD) || (state == CK_HI) || (state == CK_LO);
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         csum     <= 8'h00;
         len      <= 7'd0;
         fld      <= 4'd0;
         dcnt     <= 3'd0;
         bad      <= 1'b0;
         sh_time  <= 24'h000000;
         sh_fix   <= 1'b0;
         addr_sr  <= 16'h0000;
         ck_hi    <= 4'h0;
         time_bcd <= 24'h000000;
         fix      <= 1'b0;
         update   <= 1'b0;
         err      <= 1'b0;
      end else begin
         update <= 1'b0;
         err    <= 1'b0;
         if (valid) begin
            if (data == CH_DOLLAR) begin
               // Restart from any state; only an abandoned RMC sentence is an error
               if (in_match) err <= 1'b1;
               state   <= ADDR;
               csum    <= 8'h00;
               len     <= 7'd1;
               fld     <= 4'd0;
               dcnt    <= 3'd0;
               bad     <= 1'b0;
               sh_time <= 24'h000000;
               sh_fix  <= 1'b0;
               addr_sr <= 16'h0000;
            end else if ((state == IDLE) || (state == IGNORE)) begin
               state <= state;
            end else if (over_len || is_eol) begin
               err   <= 1'b1;
               state <= IDLE;
            end else begin
               len <= len_inc;
               case (state)
                  ADDR: begin
                     csum    <= csum ^ data;
                     addr_sr <= {addr_sr[7:0], data};
                     if (len == 7'd5)
                        state <= ({addr_sr, data} == sentence) ? FIELD : IGNORE;
                  end
                  FIELD: begin
                     if (data == CH_STAR) begin
                        state <= CK_HI;
                     end else begin
                        csum <= csum ^ data;
                        if (data == CH_COMMA) begin
                           if ((fld == 4'd1) && (dcnt != 3'd6)) bad <= 1'b1;
                           if (fld != 4'hF) fld <= fld + 4'd1;
                           dcnt <= 3'd0;
                        end else begin
                           case (fld)
                              4'd0: bad <= 1'b1;
                              4'd1: begin
                                 // Fractional seconds after the 6th digit are dropped
                                 if (dcnt != 3'd6) begin
                                    if (is_digit(data)) begin
                                       sh_time <= {sh_time[19:0], data[3:0]};
                                       dcnt    <= dcnt + 3'd1;
                                    end else begin
                                       bad <= 1'b1;
                                    end
                                 end
                              end
                              4'd2: begin
                                 if (data == CH_A)      sh_fix <= 1'b1;
                                 else if (data == CH_V) sh_fix <= 1'b0;
                                 else                   bad    <= 1'b1;
                              end
                              default: ;
                           endcase
                        end
                     end
                  end
                  CK_HI: begin
                     if (hex_ok) begin
                        ck_hi <= hex_val;
                        state <= CK_LO;
                     end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                     end
                  end
                  CK_LO: begin
                     state <= IDLE;
                     if (hex_ok && ({ck_hi, hex_val} == csum) && !bad && (fld >= 4'd2)) begin
                        time_bcd <= sh_time;
                        fix      <= sh_fix;
                        update   <= 1'b1;
                     end else begin
                        err <= 1'b1;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_nmea_rmc_parser.sv
// Bench for nmea_rmc_parser: directed sentences plus randomized RMC/GGA traffic
// scored against a string-level model of the sentence rules.
module tb_nmea_rmc_parser;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  data = 8'h00;
   logic        valid = 1'b0;
   logic [23:0] time_bcd;
   logic        fix;
   logic        update;
   logic        err;
   logic [2:0]  fsm_state;

   int n_cmp = 0;
   int n_bad = 0;
   int upd_cnt = 0;
   int err_cnt = 0;

   logic [23:0] exp_time = 24'h0;
   logic        exp_fix = 1'b0;
   logic [24:0] exp_q[$];

   string crlf = "\015\012";
   string t1_body = "GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W";

   nmea_rmc_parser dut (
      .clk       (clk),
      .rst       (rst),
      .data      (data),
      .valid     (valid),
      .time_bcd  (time_bcd),
      .fix       (fix),
      .update    (update),
      .err       (err),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: each update pulse must match the oldest predicted {fix,time}
   always @(negedge clk) begin
      if (rst && update) begin
         upd_cnt++;
         check("update_predicted", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("update_value", {7'd0, fix, time_bcd}, {7'd0, exp_q.pop_front()});
      end
      if (rst && err) err_cnt++;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      data  = b;
      valid = 1'b1;
      if (gap > 0) begin
         @(negedge clk);
         valid = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
   endtask

   task automatic idle();
      @(negedge clk);
      valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   function automatic string with_ck(input string body, input int mode);
      logic [7:0] cs = 8'h00;
      for (int i = 0; i < body.len(); i++) cs ^= body[i];
      if (mode == 2) cs ^= 8'h01;
      if (mode == 1) return {"$", body, "*", $sformatf("%02x", cs), crlf};
      return {"$", body, "*", $sformatf("%02X", cs), crlf};
   endfunction

   function automatic logic hex_char(input logic [7:0] c);
      return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
   endfunction

   function automatic logic [3:0] hex_value(input logic [7:0] c);
      logic [7:0] v;
      if (c >= "0" && c <= "9") v = c - "0";
      else if (c >= "a") v = c - "a" + 8'd10;
      else v = c - "A" + 8'd10;
      return v[3:0];
   endfunction

   // Outcome of one complete sentence fed from IDLE: 0 silent, 1 update, 2 err
   task automatic model(input string s, output int kind, output logic [23:0] t, output logic f);
      int p;
      logic [7:0] cs;
      logic [7:0] ch;
      logic good;
      string cur;
      string fl[$];
      kind = 0;
      t = 24'h0;
      f = 1'b0;
      p = -1;
      if (s.len() < 6) return;
      if (s.substr(3, 5) != "RMC") return;
      for (int i = 6; i < s.len(); i++) begin
         if (i + 1 > 82) begin kind = 2; return; end
         if (s[i] == "*") begin p = i; break; end
         if (s[i] == 8'h0d || s[i] == 8'h0a) begin kind = 2; return; end
      end
      if (p < 0 || p + 2 >= s.len()) return;
      if (p + 3 > 82) begin kind = 2; return; end
      if (!hex_char(s[p+1]) || !hex_char(s[p+2])) begin kind = 2; return; end
      cs = 8'h00;
      for (int i = 1; i < p; i++) cs ^= s[i];
      cur = "";
      for (int i = 6; i < p; i++) begin
         if (s[i] == ",") begin fl.push_back(cur); cur = ""; end
         else cur = {cur, s.substr(i, i)};
      end
      fl.push_back(cur);
      good = (cs == {hex_value(s[p+1]), hex_value(s[p+2])}) && (fl[0] == "") && (fl.size() >= 3);
      if (good) begin
         if (fl[1].len() < 6) good = 1'b0;
         else for (int k = 0; k < 6; k++) begin
            ch = fl[1][k];
            if (ch < "0" || ch > "9") good = 1'b0;
            t = {t[19:0], ch[3:0]};
         end
         for (int k = 0; k < fl[2].len(); k++) begin
            ch = fl[2][k];
            if (ch == "A") f = 1'b1;
            else if (ch == "V") f = 1'b0;
            else good = 1'b0;
         end
      end
      kind = good ? 1 : 2;
   endtask

   task automatic run_sentence(input string s, input int gap, input string tag);
      int kind;
      logic [23:0] t;
      logic f;
      int u0;
      int e0;
      u0 = upd_cnt;
      e0 = err_cnt;
      model(s, kind, t, f);
      if (kind == 1) begin
         exp_q.push_back({f, t});
         exp_time = t;
         exp_fix = f;
      end
      send_str(s, gap);
      idle();
      check({tag, "_update_count"}, upd_cnt - u0, 32'(kind == 1));
      check({tag, "_err_count"}, err_cnt - e0, 32'(kind == 2));
      check({tag, "_time"}, time_bcd, exp_time);
      check({tag, "_fix"}, fix, exp_fix);
   endtask

   initial begin
      string s;
      string body;
      string tm;
      int u0;
      int e0;
      int corr;
      int bad_k;
      int gap;

      // reset
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_time", time_bcd, 24'h0);
      check("reset_fix", fix, 1'b0);
      check("reset_update", update, 1'b0);
      check("reset_err", err, 1'b0);

      // canonical sentence, slow byte rate
      run_sentence(with_ck(t1_body, 0), 9, "t1");
      check("t1_time_literal", time_bcd, 24'h123519);
      check("t1_fix_literal", fix, 1'b1);

      // corrupted checksum keeps previous outputs
      run_sentence(with_ck(t1_body, 2), 1, "bad_ck");
      check("bad_ck_time_held", time_bcd, 24'h123519);

      // GGA is ignored, then GNRMC back-to-back
      run_sentence(with_ck("GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,", 0), 0, "gga");
      run_sentence(with_ck("GNRMC,235959.00,V,4807.038,N,01131.000,E,,,230394,,", 0), 0, "gnrmc");
      check("gnrmc_time_literal", time_bcd, 24'h235959);
      check("gnrmc_fix_literal", fix, 1'b0);

      // truncated sentence abandoned by a new '$'
      send_str("$GPRMC,1235,A", 0);
      idle();
      u0 = upd_cnt;
      e0 = err_cnt;
      exp_q.push_back({1'b1, 24'h123519});
      exp_time = 24'h123519;
      exp_fix = 1'b1;
      send_byte("$", 0);
      idle();
      check("restart_err", err_cnt - e0, 1);
      check("restart_no_update", upd_cnt - u0, 0);
      s = with_ck(t1_body, 0);
      send_str(s.substr(1, s.len() - 1), 0);
      idle();
      check("restart_update", upd_cnt - u0, 1);
      check("restart_time", time_bcd, 24'h123519);

      // lowercase checksum digits
      run_sentence(with_ck(t1_body, 1), 2, "lower_hex");

      // exactly 82 characters is accepted
      body = "GPRMC,112233,V,";
      while (body.len() < 78) body = {body, "5"};
      run_sentence(with_ck(body, 0), 0, "len82");

      // 90 characters without '*': error exactly on the 83rd
      s = "$GPRMC,112233,A,";
      while (s.len() < 90) s = {s, "7"};
      u0 = upd_cnt;
      e0 = err_cnt;
      for (int i = 0; i < 82; i++) send_byte(s[i], 0);
      idle();
      check("len_at_82_no_err", err_cnt - e0, 0);
      send_byte(s[82], 0);
      idle();
      check("len_at_83_err", err_cnt - e0, 1);
      send_str({s.substr(83, s.len() - 1), crlf}, 0);
      idle();
      check("len_overrun_single_err", err_cnt - e0, 1);
      check("len_overrun_no_update", upd_cnt - u0, 0);
      check("len_overrun_time_held", time_bcd, 24'h112233);

      // reset in the middle of the time field
      u0 = upd_cnt;
      e0 = err_cnt;
      send_str("$GPRMC,12", 0);
      @(negedge clk);
      valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      idle();
      exp_time = 24'h0;
      exp_fix = 1'b0;
      check("midreset_time", time_bcd, 24'h0);
      check("midreset_fix", fix, 1'b0);
      check("midreset_no_update", upd_cnt - u0, 0);
      check("midreset_no_err", err_cnt - e0, 0);
      run_sentence(with_ck(t1_body, 0), 0, "post_reset");

      // randomized traffic
      for (int n = 0; n < 30; n++) begin
         corr = $urandom_range(0, 9);
         bad_k = $urandom_range(0, 5);
         tm = "";
         for (int k = 0; k < ((corr == 1) ? 4 : 6); k++) begin
            if (corr == 0 && k == bad_k) tm = {tm, "x"};
            else tm = {tm, $sformatf("%0d", $urandom_range(0, 9))};
         end
         if ($urandom_range(0, 1) == 1) tm = {tm, ".", $sformatf("%02d", $urandom_range(0, 99))};
         case ($urandom_range(0, 2))
            0: body = "GP";
            1: body = "GN";
            default: body = "GL";
         endcase
         body = {body, ($urandom_range(0, 5) == 0) ? "GGA" : "RMC", ",", tm, ","};
         if (corr == 2) body = {body, "X"};
         else body = {body, ($urandom_range(0, 1) == 1) ? "A" : "V"};
         for (int k = 0; k < $urandom_range(0, 5); k++)
            body = {body, ",", $sformatf("%0d", $urandom_range(0, 9999))};
         gap = $urandom_range(0, 3);
         run_sentence(with_ck(body, (corr == 3) ? 2 : $urandom_range(0, 1)), gap, $sformatf("rand%0d", n));
      end

      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nmea_rmc_parser.md
Name: nmea_rmc_parser

Overview:
Consumes the byte stream from the UART receive stage (`data` byte plus one-cycle `valid` strobe) and parses NMEA 0183 RMC sentences (`$xxRMC,...*hh`). It extracts UTC time as BCD hh:mm:ss and the fix status, and verifies the XOR checksum. On a good sentence it latches both into holding registers and pulses `update`. It feeds the display time/alignment logic downstream.

Parameters:
- `maxlen`, default 82: maximum characters from `$` through the last checksum digit (the NMEA limit); exceeding it aborts the sentence.
- `sentence`, default "RMC": 24-bit ASCII sentence ID to match in address chars 3-5. Talker chars 1-2 are not checked, so GP, GN and GL are all accepted.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `data`  in  8  received byte, qualified by `valid`.
- `valid`  in  1  one-cycle strobe; `data` is stable in that cycle. May be asserted on consecutive cycles.
- `time_bcd`  out  24  {H1,H0,M1,M0,S1,S0}, one BCD nibble each, from the last good sentence.
- `fix`  out  1  1 when the last good sentence had status 'A', 0 when 'V'.
- `update`  out  1  one-cycle pulse when `time_bcd`/`fix` are reloaded.
- `err`  out  1  one-cycle pulse when a matching sentence is rejected.

Behaviour:
- Reset (async assert, sync release): `time_bcd`=0, `fix`=0, `update`=0, `err`=0, state IDLE, all counters and shadow registers cleared. Reset mid-sentence discards the partial sentence with no pulse.
- All state advances only on `valid`=1 cycles. `update`/`err` default to 0 every cycle.
- Running registers:
  - `csum` (8b): XOR of every byte strictly between `$` and `*`.
  - `len` (7b): count of characters from `$` onward.
  - `fld` (4b): field index, incremented on each ',' in FIELD state.
  - `dcnt` (3b): digit count within the time field.
  - `bad` (1b): set by any field-content violation.
  - Shadow time/fix registers.
- States:
  - IDLE: wait for '$'; then `csum`=0, `len`=1, `bad`=0, shadows cleared → ADDR.
  - ADDR: collect 5 chars, XOR into `csum`. After the 5th, compare chars 3-5 to `sentence`. Match → FIELD with `fld`=0 (next char must be ','). Mismatch → IGNORE.
  - IGNORE: wait for '$' (restart) and nothing else; never pulses `err`.
  - FIELD:
    - ',' → `fld`++.
    - In field 1, the first 6 chars must be '0'-'9' and are shifted into shadow time. Chars after the 6th (e.g. ".sss") are ignored. A non-digit among the first 6, or fewer than 6 digits at the closing ',', sets `bad`.
    - In field 2: 'A' → shadow fix=1, 'V' → 0, anything else sets `bad`.
    - '*' → CK_HI, without XOR.
  - CK_HI / CK_LO: accept '0'-'9', 'A'-'F' or 'a'-'f' as hex nibbles. After CK_LO, compare to `csum`.
    - Equal and `bad`=0 and `fld`≥2 → load `time_bcd` and `fix`, pulse `update`.
    - Otherwise pulse `err`.
    - → IDLE in both cases.
- Errors in ADDR, FIELD, CK_HI or CK_LO: pulse `err` and go to IDLE on any of:
  - a non-hex char in CK_HI/CK_LO;
  - CR or LF before the checksum completes;
  - `len` exceeding `maxlen`.
- '$' in any non-IDLE state restarts the sentence as in IDLE. If the abandoned sentence was a matching one (FIELD or CK_*), also pulse `err` in the same cycle.
- Latency: `update`/`err` asserts in the cycle after the `valid` cycle carrying the second checksum digit (registered output). Outputs hold their values until the next `update`.
- No range check on time values (e.g. "99"): BCD is passed through unchanged.

Decomposition:
- Package `nmea_pkg`:
  - ASCII constants: '$', '*', ',', CR, LF, 'A', 'V'.
  - State enum: IDLE, ADDR, IGNORE, FIELD, CK_HI, CK_LO.
  - Function `is_digit`.
- Sub-module `nmea_hex_nibble`: ASCII → {ok, nibble[3:0]}. Used for the checksum digits only.

Test Plan:
- "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A\r\n", one byte every 10 clocks → one `update`; `time_bcd`=24'h123519, `fix`=1, `err` never high.
- Same sentence with "*6B" → one `err`; `time_bcd`/`fix` keep their previous values.
- "$GPGGA,..." valid sentence, then "$GNRMC,235959.00,V,...*hh" (correct checksum), with `valid` on back-to-back cycles → GGA is silent; RMC gives `update` with `time_bcd`=24'h235959, `fix`=0.
- "$GPRMC,1235,A" then "$GPRMC,123519,A,...*6A" → `err` at the second '$', then `update` with 24'h123519.
- Lowercase "*6a", and a 90-char sentence with no '*' → first gives `update`; second gives `err` when `len` reaches 83.
- `rst` low for 1 cycle mid-field-1 → outputs back to 0 with no pulse; the next good sentence gives a normal `update`.
